// File: rtl/demux_1_4_buffered.sv
// demux_1_4_buffered: 1-to-4 valid/ready stream demultiplexer.
// Each accepted input word is routed by in_sel into one of four independent
// per-channel FIFOs. A stalled consumer only blocks words addressed to it.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready input stream handshake (in_ready = ~full[in_sel])
//   in_sel            destination channel 0..3
//   in_data           input word
//   out_valid[k]      channel k FIFO non-empty
//   out_ready[k]      consumer k takes channel k head word
//   out_data0..3      head word of channel 0..3
module demux_1_4_buffered #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3
);

  localparam int unsigned NCH = 4;
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;

  logic [NCH-1:0]   full_c;
  logic [NCH-1:0]   push_c;
  logic [NCH-1:0]   pop_c;
  logic [WIDTH-1:0] data_c [NCH];

  // Ready depends only on the addressed channel's registered fill level.
  assign in_ready = ~full_c[in_sel];

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;

    assign full_c[k]    = (count_q == CW'(DEPTH));
    assign out_valid[k] = (count_q != CW'(0));
    // in_valid gates the select so an unknown in_sel while idle cannot write.
    assign push_c[k]    = in_valid & in_ready & (in_sel == 2'(k));
    assign pop_c[k]     = out_valid[k] & out_ready[k];
    assign data_c[k]    = mem_q[rd_ptr_q];

    // Next-state pointers and fill count; pointers wrap modulo DEPTH.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_c[k]) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_c[k])  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_c[k], pop_c[k]})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // Channel state and storage; reset clears everything, including data.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mem_q    <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_c[k]) mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end
  end

  assign out_data0 = data_c[0];
  assign out_data1 = data_c[1];
  assign out_data2 = data_c[2];
  assign out_data3 = data_c[3];

`ifndef SYNTHESIS
  // The select must be known whenever a word is offered.
  a_sel_known: assert property (@(posedge clk) disable iff (rst)
    in_valid |-> !$isunknown(in_sel));
`endif

endmodule

// File: doc/demux_1_4_buffered.md
Name: demux_1_4_buffered

Overview:
- 1-to-4 stream demultiplexer, the distributing counterpart of the 4:1 case-based mux.
- A single valid/ready input stream carries a data word and a 2-bit destination select. Each accepted word goes to one of four independent output streams.
- Each output channel has its own small FIFO, so a stalled consumer blocks only traffic addressed to it.
- Sits between a single producer and four consumers in the combinational-logic exercise datapath.

Parameters:
- WIDTH, 4, data word width in bits (>=1).
- DEPTH, 2, per-channel FIFO depth in entries (power of two, >=2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the word addressed by in_sel.
- in_sel  input  2  destination channel 0..3; meaningful only while in_valid=1.
- in_data  input  WIDTH  input word.
- out_valid  output  4  bit k: channel k FIFO non-empty.
- out_ready  input  4  bit k: consumer k takes the head word.
- out_data0  output  WIDTH  channel 0 head word.
- out_data1  output  WIDTH  channel 1 head word.
- out_data2  output  WIDTH  channel 2 head word.
- out_data3  output  WIDTH  channel 3 head word.

Behaviour:
- Reset, asynchronous, active-high: all FIFOs empty; read/write pointers and counts = 0; out_valid=4'b0000; out_data0..3 = 0 (all storage is cleared). Reset asserted mid-operation discards all buffered words immediately.
- in_ready = ~full[in_sel]. It is combinational from in_sel and registered state only. There is no combinational path from out_ready to in_ready.
- Push: on a rising edge with in_valid & in_ready, in_data is written into the FIFO of channel in_sel. Exactly one channel is written per cycle.
- Pop: on a rising edge with out_valid[k] & out_ready[k], channel k advances its read pointer. All four channels may pop in the same cycle.
- Latency: a word accepted at edge N appears on out_data[in_sel] with out_valid set after edge N (one cycle, registered). No bypass from input to output.
- Ordering: per-channel order is FIFO. There is no ordering guarantee across channels.
- Head-of-line isolation: a full channel deasserts in_ready only while in_sel points to it. The producer may change in_sel while in_valid=1 and in_ready=0; the block does not require the input to be held stable.
- Push and pop on the same channel in the same cycle:
  - If the channel is not full, both happen and the count is unchanged.
  - If the channel is full, in_ready=0, so only the pop occurs. The push retries next cycle.
- Pop on an empty channel: ignored because out_valid=0. Pointers and count do not move.
- in_valid=0: no write, whatever in_sel and in_data are.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Count: log2(DEPTH)+1 bits, range 0..DEPTH.
  - full = (count==DEPTH), empty = (count==0).
- out_dataK always shows the storage entry at channel K's read pointer. Its value is defined only while out_valid[K]=1; after reset it is 0.
- X on in_sel while in_valid=0 must not corrupt state. Assertions check that in_sel is known whenever in_valid=1.

Test Plan:
- Reset sweep: drive rst=1 mid-stream with 2 words buffered in channel 1 -> out_valid=0000 and all out_data=0 immediately (asynchronous); after release, in_ready=1 for every in_sel.
- Routing: send 4'hA sel=0, 4'hB sel=1, 4'hC sel=2, 4'hD sel=3 on consecutive cycles with out_ready=0000 -> out_valid becomes 0001, 0011, 0111, 1111 on successive cycles; out_data0..3 = A,B,C,D.
- Full/backpressure with DEPTH=2 and out_ready=0000: push 4'h1, then 4'h2 to sel=2 -> in_ready=0 while sel=2. Switch sel=0 and push 4'h5 -> it is accepted, in_ready=1.
- Simultaneous push/pop on full channel 2 (holding 1,2): set out_ready[2]=1 and offer 4'h3 -> 4'h1 pops this cycle and the push is refused. Next cycle 4'h3 is accepted. Drain order observed: 1,2,3.
- Streaming: continuous words 0..15 round-robin over sel 0..3 with out_ready=1111 -> in_ready stays 1 every cycle; each channel outputs its words in order, one cycle after acceptance; no drops or duplicates (scoreboard).
- Random: 10k cycles of random in_valid, in_sel and out_ready -> per-channel scoreboard matches; there is never a push with in_ready=0, and never a pop when out_valid=0.
